data_mem_arbiter: RTL

//   Shares one single-port synchronous data memory between the CPU load/store port and a loader/debug port.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/data_mem_arbiter_rr_arb2.sv | 45 ++++
 rtl/data_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package riscv_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  localparam logic [1:0] STORE_WORD = 2'b10;

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant between CPU and loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arb2
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_en,
  input  logic   i_req_cpu,
  input  logic   i_req_ldr,
  output logic   o_gnt_valid,
  output owner_t o_gnt_owner
);

  owner_t r_last_gnt;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    o_gnt_valid = i_en & (i_req_cpu | i_req_ldr);
    if (i_req_cpu && i_req_ldr) begin
      o_gnt_owner = (r_last_gnt == OWN_LDR) ? OWN_CPU : OWN_LDR;
    end else if (i_req_ldr) begin
      o_gnt_owner = OWN_LDR;
    end else begin
      o_gnt_owner = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_gnt <= OWN_LDR;
    end else if (o_gnt_valid) begin
      r_last_gnt <= o_gnt_owner;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares a single-port data memory between CPU and loader port.
//               Optional macro ARB_PERF_CNT_EN adds stall/grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_store,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_store,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_ldr_cnt
`endif
);

  localparam int LAT_W = 2;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_owner;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              w_arb_en;
  logic              w_gnt;
  owner_t            w_gnt_own;
  logic              w_issue_we;
  logic              w_rd_last;
  logic              w_cpu_done;

  // Combinational outputs are gated by reset so they clear the moment it asserts.
  assign w_arb_en   = reset & (r_state == IDLE);
  assign w_issue_we = (w_gnt_own == OWN_CPU) ? cpu_we : ldr_we;
  assign w_rd_last  = reset & (r_state == RD_WAIT) & (r_lat_cnt == '0);

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_arb_en),
    .i_req_cpu   (cpu_req),
    .i_req_ldr   (ldr_req),
    .o_gnt_valid (w_gnt),
    .o_gnt_owner (w_gnt_own)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt && !w_issue_we) w_state_nxt = RD_WAIT;
      RD_WAIT: if (r_lat_cnt == '0)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_store  = '0;
    ldr_gnt    = 1'b0;
    ldr_rvalid = 1'b0;
    w_cpu_done = 1'b0;
    if (w_gnt) begin
      mem_en = 1'b1;
      mem_we = w_issue_we;
      if (w_gnt_own == OWN_CPU) begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_store  = cpu_store;
        w_cpu_done = cpu_we;
      end else begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_store = STORE_WORD;
        ldr_gnt   = 1'b1;
      end
    end
    if (w_rd_last) begin
      if (r_owner == OWN_CPU) w_cpu_done = 1'b1;
      else                    ldr_rvalid = 1'b1;
    end
  end

  assign cpu_stall = reset & cpu_req & ~w_cpu_done;
  // Read data is forwarded in the completion cycle, then held by the register.
  assign cpu_rdata = (w_rd_last && r_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : r_ldr_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt   <= '0;
      r_owner     <= OWN_CPU;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      if (w_gnt && !w_issue_we) begin
        r_lat_cnt <= LAT_W'(MEM_LAT - 1);
        r_owner   <= w_gnt_own;
      end else if (r_state == RD_WAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      if (w_rd_last) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
        else                    r_ldr_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_ldr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_ldr_cnt   <= '0;
    end else begin
      if (cpu_stall && r_perf_stall_cnt != 32'hFFFF_FFFF) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (ldr_gnt && r_perf_ldr_cnt != 32'hFFFF_FFFF)     r_perf_ldr_cnt   <= r_perf_ldr_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_ldr_cnt   = r_perf_ldr_cnt;
`endif

endmodule

`default_nettype wire
